key_evt_arb: RTL and testbench

KEY_EVT_ARB -- requirements
Module: key_evt_arb

---
 rtl/key_evt_pkg.sv | 16 +
 rtl/btn_deb.sv | 34 +++
 rtl/key_rr_pick.sv | 35 +++
 rtl/key_evt_arb.sv | 122 ++++++++++++
 tb/tb_key_evt_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the push-button event arbiter.
package key_evt_pkg;

   localparam int N_KEY_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

   // Width of a key index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_deb.sv
// Single-button debouncer: two-flop synchroniser followed by a down-counter
// that must reach terminal count with the input stable before the output moves.
module btn_deb #(
   parameter int              DEB_W    = 16,
   parameter logic [DEB_W-1:0] DEB_LOAD = '1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic deb
);

   logic [1:0]       sync;
   logic [DEB_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         cnt  <= DEB_LOAD;
         deb  <= 1'b1;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == deb) begin
            cnt <= DEB_LOAD;
         end else if (cnt == '0) begin
            deb <= sync[1];
            cnt <= DEB_LOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_rr_pick.sv
// Combinational round-robin selector: first pending key after last_grant wins.
module key_rr_pick
   import key_evt_pkg::*;
#(
   parameter int N_KEY = N_KEY_DEF
) (
   input  logic [N_KEY-1:0]          pending,
   input  logic [id_w(N_KEY)-1:0]    last_grant,
   output logic [id_w(N_KEY)-1:0]    grant_id,
   output logic                      any_pending
);

   localparam int IW = id_w(N_KEY);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant_id    = '0;
      any_pending = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int k = 1; k <= N_KEY; k++) begin
         // Modulo by conditional subtract keeps this valid for non-power-of-2 N_KEY.
         sum = {1'b0, last_grant} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_KEY)) sum = sum - (IW+1)'(N_KEY);
         idx = sum[IW-1:0];
         if (!any_pending && pending[idx]) begin
            any_pending = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/key_evt_arb.sv
// Push-button event arbiter: debounce, press detect, per-key pending/overrun
// tracking and a round-robin valid/ready event offer with per-key sequence numbers.
//
//   state | meaning
//   IDLE  | no event offered; picks next pending key round-robin
//   OFFER | evt_valid high, evt_id/evt_seq held until evt_ready
module key_evt_arb
   import key_evt_pkg::*;
#(
   parameter int N_KEY = N_KEY_DEF,
   parameter bit SIM   = 1'b0,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_KEY-1:0]        btn,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [id_w(N_KEY)-1:0]  evt_id,
   output logic [CNT_W-1:0]        evt_seq,
   output logic [N_KEY-1:0]        ovf,
   input  logic                    ovf_clr
);

   localparam int IW = id_w(N_KEY);

   logic [N_KEY-1:0] deb, deb_q, press, pending, done, overrun;
   logic [CNT_W-1:0] seq [N_KEY];
   logic [IW-1:0]    last_grant, grant_id;
   logic             any_pending, fire, latch;
   arb_state_t       state_q, state_d;

   generate
      if (SIM) begin : g_bypass
         assign deb = btn;
      end else begin : g_deb
         for (genvar i = 0; i < N_KEY; i++) begin : g_key
            btn_deb u_deb (
               .clk   (clk),
               .rst_n (rst_n),
               .raw   (btn[i]),
               .deb   (deb[i])
            );
         end
      end
   endgenerate

   // Released-state reset value means reset release cannot look like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) deb_q <= '1;
      else        deb_q <= deb;
   end

   assign press = deb_q & ~deb;
   assign fire  = (state_q == OFFER) && evt_ready;

   always_comb begin
      done = '0;
      if (fire) done[evt_id] = 1'b1;
      overrun = press & pending & ~done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         ovf     <= '0;
      end else begin
         pending <= (pending & ~done) | press;
         ovf     <= (ovf_clr ? '0 : ovf) | overrun;
      end
   end

   key_rr_pick #(.N_KEY(N_KEY)) u_pick (
      .pending     (pending),
      .last_grant  (last_grant),
      .grant_id    (grant_id),
      .any_pending (any_pending)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      latch     = 1'b0;
      evt_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_pending) begin
               latch   = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            evt_valid = 1'b1;
            if (evt_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_id     <= '0;
         evt_seq    <= '0;
         last_grant <= IW'(N_KEY - 1);
         for (int i = 0; i < N_KEY; i++) seq[i] <= '0;
      end else begin
         if (latch) begin
            evt_id  <= grant_id;
            evt_seq <= seq[grant_id] + CNT_W'(1);
         end
         if (fire) begin
            seq[evt_id] <= seq[evt_id] + CNT_W'(1);
            last_grant  <= evt_id;
         end
      end
   end

endmodule

// File: tb/tb_key_evt_arb.sv
// Self-checking bench for key_evt_arb (SIM=1, N_KEY=4, CNT_W=8): directed
// scenarios plus randomized traffic against an event-level reference model.
module tb_key_evt_arb;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn;
   logic       evt_ready;
   logic       ovf_clr;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [7:0] evt_seq;
   logic [3:0] ovf;

   int checks   = 0;
   int failures = 0;

   logic       pre_valid;
   logic [1:0] pre_id;
   logic [7:0] pre_seq;
   bit         hs;

   // Reference model state
   bit         m_pend [N];
   int         m_seq  [N];
   logic [3:0] m_ovf;
   int         m_last;
   bit         m_valid;
   int         m_id;
   int         m_eseq;
   logic [3:0] m_btn;

   key_evt_arb #(.N_KEY(4), .SIM(1'b1), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_id    (evt_id),
      .evt_seq   (evt_seq),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_seq[i]  = 0;
      end
      m_ovf   = '0;
      m_last  = N - 1;
      m_valid = 1'b0;
      m_id    = 0;
      m_eseq  = 0;
      m_btn   = '1;
   endtask

   // One clock of behaviour: presses are falling edges, a handshake retires the
   // offered key, and an idle arbiter offers the first pending key after the last grant.
   task automatic model_step(input logic [3:0] b, input bit r, input bit c);
      bit         fire;
      bit         old_pend [N];
      logic [3:0] ov;
      bit         found;
      int         pick;
      fire     = m_valid && r;
      old_pend = m_pend;
      ov       = '0;
      found    = 1'b0;
      pick     = 0;
      for (int i = 0; i < N; i++) begin
         if (m_btn[i] && !b[i]) begin
            if (m_pend[i] && !(fire && m_id == i)) ov[i] = 1'b1;
            m_pend[i] = 1'b1;
         end else if (fire && m_id == i) begin
            m_pend[i] = 1'b0;
         end
      end
      m_ovf = (c ? 4'b0000 : m_ovf) | ov;
      if (fire) begin
         m_seq[m_id] = (m_seq[m_id] + 1) % 256;
         m_last      = m_id;
         m_valid     = 1'b0;
      end else if (!m_valid) begin
         for (int k = 1; k <= N; k++) begin
            if (!found && old_pend[(m_last + k) % N]) begin
               found = 1'b1;
               pick  = (m_last + k) % N;
            end
         end
         if (found) begin
            m_valid = 1'b1;
            m_id    = pick;
            m_eseq  = (m_seq[pick] + 1) % 256;
         end
      end
      m_btn = b;
   endtask

   task automatic tick(input logic [3:0] b, input bit r, input bit c);
      @(negedge clk);
      pre_valid = evt_valid;
      pre_id    = evt_id;
      pre_seq   = evt_seq;
      hs        = evt_valid && r;
      btn       = b;
      evt_ready = r;
      ovf_clr   = c;
      model_step(b, r, c);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      btn       = '1;
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; btn = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      #12;
      checks++;
      if ({evt_valid, evt_id, evt_seq, ovf} !== 15'd0) begin
         failures++;
         $display("FAIL reset_values: valid=%b id=%0d seq=%0d ovf=%b, required all 0", evt_valid, evt_id, evt_seq, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(4'b1111, 1'b1, 1'b0);
         checks++;
         if (evt_valid !== 1'b0 || ovf !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_quiet: valid=%b ovf=%b, required 0 and 0000", evt_valid, ovf);
         end
      end
   endtask

   task automatic test_single_press();
      do_reset();
      tick(4'b1011, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_early: valid=%b one cycle after press, required 0", evt_valid);
      end
      tick(4'b1011, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_seq !== 8'd1) begin
         failures++;
         $display("FAIL single_offer: valid=%b id=%0d seq=%0d, required 1 2 1", evt_valid, evt_id, evt_seq);
      end
      tick(4'b1111, 1'b1, 1'b0);
      checks++;
      if (!hs || evt_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_one_cycle: hs=%b valid_after=%b, required 1 0", hs, evt_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick(4'b1111, 1'b1, 1'b0);
         checks++;
         if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_no_repeat: valid=%b, required 0", evt_valid);
         end
      end
   endtask

   task automatic test_round_robin();
      int ev_id[$];
      int ev_seq[$];
      int ev_cyc[$];
      int exp_id[5]  = '{0, 1, 3, 0, 3};
      int exp_seq[5] = '{1, 1, 1, 2, 2};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         tick(4'b0100, 1'b1, 1'b0);
         if (hs) begin ev_id.push_back(pre_id); ev_seq.push_back(pre_seq); ev_cyc.push_back(c); end
      end
      tick(4'b1111, 1'b1, 1'b0);
      for (int c = 20; c < 30; c++) begin
         tick(4'b0110, 1'b1, 1'b0);
         if (hs) begin ev_id.push_back(pre_id); ev_seq.push_back(pre_seq); ev_cyc.push_back(c); end
      end
      checks++;
      if (ev_id.size() != 5) begin
         failures++;
         $display("FAIL rr_count: events=%0d, required 5", ev_id.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (ev_id[i] != exp_id[i] || ev_seq[i] != exp_seq[i]) begin
               failures++;
               $display("FAIL rr_order[%0d]: id=%0d seq=%0d, required id=%0d seq=%0d", i, ev_id[i], ev_seq[i], exp_id[i], exp_seq[i]);
            end
         end
         checks++;
         if (ev_cyc[0] != 2 || ev_cyc[1] != 4 || ev_cyc[2] != 6 || ev_cyc[4] - ev_cyc[3] != 2) begin
            failures++;
            $display("FAIL rr_spacing: cycles %0d %0d %0d %0d %0d, required 2 4 6 and 2 apart", ev_cyc[0], ev_cyc[1], ev_cyc[2], ev_cyc[3], ev_cyc[4]);
         end
      end
   endtask

   task automatic test_backpressure();
      int n_ev;
      bit ok;
      do_reset();
      tick(4'b1101, 1'b0, 1'b0);
      tick(4'b1101, 1'b0, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_seq !== 8'd1) begin
         failures++;
         $display("FAIL bp_offer: valid=%b id=%0d seq=%0d, required 1 1 1", evt_valid, evt_id, evt_seq);
      end
      tick(4'b1111, 1'b0, 1'b0);
      tick(4'b1101, 1'b0, 1'b0);
      checks++;
      if (ovf !== 4'b0010) begin
         failures++;
         $display("FAIL bp_overrun: ovf=%b, required 0010", ovf);
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(4'b1101, 1'b0, 1'b0);
         if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_seq !== 8'd1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_hold: valid=%b id=%0d seq=%0d, required stable 1 1 1", evt_valid, evt_id, evt_seq);
      end
      n_ev = 0;
      for (int i = 0; i < 10; i++) begin
         tick(4'b1101, 1'b1, 1'b0);
         if (hs) begin
            n_ev++;
            checks++;
            if (pre_id !== 2'd1 || pre_seq !== 8'd1) begin
               failures++;
               $display("FAIL bp_event: id=%0d seq=%0d, required 1 1", pre_id, pre_seq);
            end
         end
      end
      checks++;
      if (n_ev != 1) begin
         failures++;
         $display("FAIL bp_single_event: events=%0d, required 1", n_ev);
      end
   endtask

   task automatic test_coincident();
      int n_ev;
      do_reset();
      tick(4'b1110, 1'b0, 1'b0);
      tick(4'b1110, 1'b0, 1'b0);
      tick(4'b1111, 1'b0, 1'b0);
      tick(4'b1110, 1'b1, 1'b0);
      checks++;
      if (!hs || pre_seq !== 8'd1 || ovf[0] !== 1'b0) begin
         failures++;
         $display("FAIL coinc_accept: hs=%b seq=%0d ovf0=%b, required 1 1 0", hs, pre_seq, ovf[0]);
      end
      n_ev = 0;
      for (int i = 0; i < 6; i++) begin
         tick(4'b1110, 1'b1, 1'b0);
         if (hs) begin
            n_ev++;
            checks++;
            if (pre_id !== 2'd0 || pre_seq !== 8'd2) begin
               failures++;
               $display("FAIL coinc_second: id=%0d seq=%0d, required 0 2", pre_id, pre_seq);
            end
         end
      end
      checks++;
      if (n_ev != 1) begin
         failures++;
         $display("FAIL coinc_count: events=%0d, required 1", n_ev);
      end
   endtask

   task automatic test_wrap_clear();
      logic [7:0] last_seq;
      int         bad;
      do_reset();
      bad      = 0;
      last_seq = 8'hAA;
      for (int k = 0; k < 256; k++) begin
         tick(4'b0111, 1'b1, 1'b0);
         tick(4'b0111, 1'b1, 1'b0);
         tick(4'b1111, 1'b1, 1'b0);
         if (!hs || pre_id !== 2'd3 || pre_seq !== 8'((k + 1) % 256)) bad++;
         if (hs) last_seq = pre_seq;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL wrap_sequence: bad_events=%0d, required 0", bad);
      end
      checks++;
      if (last_seq !== 8'd0) begin
         failures++;
         $display("FAIL wrap_256th: seq=%0d, required 0", last_seq);
      end
      tick(4'b0111, 1'b0, 1'b0);
      tick(4'b0111, 1'b0, 1'b0);
      tick(4'b1111, 1'b0, 1'b0);
      tick(4'b0111, 1'b0, 1'b1);
      checks++;
      if (ovf !== 4'b1000) begin
         failures++;
         $display("FAIL clr_vs_overrun: ovf=%b, required 1000", ovf);
      end
      tick(4'b0111, 1'b0, 1'b1);
      checks++;
      if (ovf !== 4'b0000) begin
         failures++;
         $display("FAIL clr_alone: ovf=%b, required 0000", ovf);
      end
      tick(4'b1111, 1'b1, 1'b0);
      tick(4'b1111, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_offer();
      do_reset();
      tick(4'b1101, 1'b0, 1'b0);
      tick(4'b1101, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || evt_seq !== 8'd0) begin
         failures++;
         $display("FAIL reset_mid_offer: valid=%b seq=%0d, required 0 0", evt_valid, evt_seq);
      end
      btn = '1;
      evt_ready = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick(4'b1011, 1'b1, 1'b0);
      tick(4'b1011, 1'b1, 1'b0);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_seq !== 8'd1) begin
         failures++;
         $display("FAIL reset_then_press: valid=%b id=%0d seq=%0d, required 1 2 1", evt_valid, evt_id, evt_seq);
      end
      tick(4'b1111, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] cur;
      bit         r, c;
      do_reset();
      cur = '1;
      for (int n = 0; n < 3000 && failures < 40; n++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
         r = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 31) == 0);
         tick(cur, r, c);
         checks++;
         if (evt_valid !== m_valid || evt_id !== 2'(m_id) || evt_seq !== 8'(m_eseq) || ovf !== m_ovf) begin
            failures++;
            $display("FAIL random[%0d]: valid=%b id=%0d seq=%0d ovf=%b, required valid=%b id=%0d seq=%0d ovf=%b",
                     n, evt_valid, evt_id, evt_seq, ovf, m_valid, m_id, m_eseq, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_round_robin();
      test_backpressure();
      test_coincident();
      test_wrap_clear();
      test_reset_mid_offer();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
